way_alloc_ctrl: RTL and testbench



---
 rtl/way_alloc_ctrl_if.sv | 49 ++++
 rtl/way_alloc_ctrl.sv | 151 +++++++++++++++
 tb/tb_way_alloc_ctrl.sv | 328 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/way_alloc_ctrl_if.sv
// Hit-touch, miss-allocation and memory-engine handshake bundle for way_alloc_ctrl.
// The controller uses the slave modport; the datapath/memory side uses master.
interface way_alloc_ctrl_if #(
    parameter int unsigned S_IDX = 3
);
    logic             hit_valid;
    logic [S_IDX-1:0] hit_index;
    logic [2:0]       hit_way;
    logic             hit_dirty;
    logic             hit_ready;

    logic             miss_req;
    logic [S_IDX-1:0] miss_index;
    logic             miss_ready;

    logic             wb_req;
    logic [S_IDX-1:0] wb_index;
    logic [2:0]       wb_way;
    logic             wb_ack;

    logic             fill_req;
    logic [S_IDX-1:0] fill_index;
    logic [2:0]       fill_way;
    logic             fill_ack;
    logic             fill_dirty;

    logic             miss_done;
    logic [2:0]       miss_way;

    modport master (
        output hit_valid, hit_index, hit_way, hit_dirty,
        output miss_req, miss_index,
        output wb_ack, fill_ack, fill_dirty,
        input  hit_ready, miss_ready,
        input  wb_req, wb_index, wb_way,
        input  fill_req, fill_index, fill_way,
        input  miss_done, miss_way
    );

    modport slave (
        input  hit_valid, hit_index, hit_way, hit_dirty,
        input  miss_req, miss_index,
        input  wb_ack, fill_ack, fill_dirty,
        output hit_ready, miss_ready,
        output wb_req, wb_index, wb_way,
        output fill_req, fill_index, fill_way,
        output miss_done, miss_way
    );
endinterface

// File: rtl/way_alloc_ctrl.sv
// 8-way allocation controller: per-set valid/dirty/pseudo-LRU state, hit touches,
// and miss sequencing through victim select, optional writeback and fill.
module way_alloc_ctrl #(
    parameter int unsigned S_IDX = 3
) (
    input  logic           clk,
    input  logic           rst_n,
    way_alloc_ctrl_if.slave bus
);
    localparam int unsigned NSETS = 1 << S_IDX;

    typedef enum logic [2:0] {IDLE, SELECT, WB, FILL, DONE} state_t;

    state_t           state_q, state_d;
    logic             sel_ph_q, sel_ph_d;
    logic [S_IDX-1:0] idx_q, idx_d;
    logic [2:0]       vic_q, vic_d;

    logic wb_req_q, fill_req_q, miss_done_q, miss_ready_q, hit_ready_q;

    logic [6:0] lru_q   [NSETS];
    logic [7:0] valid_q [NSETS];
    logic [7:0] dirty_q [NSETS];

    logic hit_fire, fill_fire;

    // Mark way w most recently used: every node on its path points away from it.
    function automatic logic [6:0] lru_touch(input logic [6:0] l, input logic [2:0] w);
        logic [6:0] n;
        n    = l;
        n[0] = ~w[2];
        if (w[2]) n[2] = ~w[1];
        else      n[1] = ~w[1];
        n[3'd3 + {1'b0, w[2:1]}] = ~w[0];
        return n;
    endfunction

    function automatic logic [2:0] lru_victim(input logic [6:0] l);
        logic [2:0] v;
        v[2] = l[0];
        v[1] = v[2] ? l[2] : l[1];
        v[0] = l[3'd3 + {1'b0, v[2:1]}];
        return v;
    endfunction

    // Lowest invalid way wins; the tree is consulted only for a full set.
    function automatic logic [2:0] pick_victim(input logic [7:0] vld, input logic [6:0] l);
        logic [2:0] v;
        logic       found;
        v     = lru_victim(l);
        found = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (!found && !vld[i]) begin
                v     = 3'(i);
                found = 1'b1;
            end
        end
        return v;
    endfunction

    assign hit_fire  = bus.hit_valid & hit_ready_q;
    assign fill_fire = (state_q == FILL) & bus.fill_ack;

    // SELECT spends one cycle registering the victim and one deciding WB vs FILL.
    always_comb begin
        state_d  = state_q;
        sel_ph_d = 1'b0;
        idx_d    = idx_q;
        vic_d    = vic_q;
        unique case (state_q)
            IDLE: begin
                if (bus.miss_req) begin
                    idx_d   = bus.miss_index;
                    state_d = SELECT;
                end
            end
            SELECT: begin
                if (!sel_ph_q) begin
                    vic_d    = pick_victim(valid_q[idx_q], lru_q[idx_q]);
                    sel_ph_d = 1'b1;
                end else if (valid_q[idx_q][vic_q] && dirty_q[idx_q][vic_q]) begin
                    state_d = WB;
                end else begin
                    state_d = FILL;
                end
            end
            WB:      if (bus.wb_ack)   state_d = FILL;
            FILL:    if (bus.fill_ack) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            sel_ph_q     <= 1'b0;
            idx_q        <= '0;
            vic_q        <= '0;
            wb_req_q     <= 1'b0;
            fill_req_q   <= 1'b0;
            miss_done_q  <= 1'b0;
            miss_ready_q <= 1'b1;
            hit_ready_q  <= 1'b1;
        end else begin
            state_q      <= state_d;
            sel_ph_q     <= sel_ph_d;
            idx_q        <= idx_d;
            vic_q        <= vic_d;
            wb_req_q     <= (state_d == WB);
            fill_req_q   <= (state_d == FILL);
            miss_done_q  <= (state_d == DONE);
            miss_ready_q <= (state_d == IDLE);
            hit_ready_q  <= (state_d != DONE);
        end
    end

    // Hits are blocked in DONE, so the hit and allocation tree writes never collide.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned s = 0; s < NSETS; s++) begin
                lru_q[S_IDX'(s)]   <= '0;
                valid_q[S_IDX'(s)] <= '0;
                dirty_q[S_IDX'(s)] <= '0;
            end
        end else begin
            if (hit_fire) begin
                lru_q[bus.hit_index] <= lru_touch(lru_q[bus.hit_index], bus.hit_way);
                if (bus.hit_dirty && valid_q[bus.hit_index][bus.hit_way])
                    dirty_q[bus.hit_index][bus.hit_way] <= 1'b1;
            end
            if (fill_fire) begin
                valid_q[idx_q][vic_q] <= 1'b1;
                dirty_q[idx_q][vic_q] <= bus.fill_dirty;
            end
            if (state_q == DONE)
                lru_q[idx_q] <= lru_touch(lru_q[idx_q], vic_q);
        end
    end

    assign bus.hit_ready  = hit_ready_q;
    assign bus.miss_ready = miss_ready_q;
    assign bus.wb_req     = wb_req_q;
    assign bus.wb_index   = idx_q;
    assign bus.wb_way     = vic_q;
    assign bus.fill_req   = fill_req_q;
    assign bus.fill_index = idx_q;
    assign bus.fill_way   = vic_q;
    assign bus.miss_done  = miss_done_q;
    assign bus.miss_way   = vic_q;
endmodule

// File: tb/tb_way_alloc_ctrl.sv
// Bench for way_alloc_ctrl: directed scenarios plus randomized hit/miss traffic
// checked against a behavioural per-set valid/dirty/PLRU model.
module tb_way_alloc_ctrl;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    way_alloc_ctrl_if #(.S_IDX(3)) bus ();

    way_alloc_ctrl #(.S_IDX(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference state: tree bits as the bit array the rules talk about.
    logic [6:0] m_lru [8];
    logic [7:0] m_val [8];
    logic [7:0] m_dty [8];

    task automatic m_reset();
        for (int s = 0; s < 8; s++) begin
            m_lru[s] = '0;
            m_val[s] = '0;
            m_dty[s] = '0;
        end
    endtask

    task automatic m_touch(input int s, input int w);
        m_lru[s][0]         = (w < 4);
        m_lru[s][1 + w / 4] = (((w / 2) % 2) == 0);
        m_lru[s][3 + w / 2] = ((w % 2) == 0);
    endtask

    function automatic int m_victim(input int s);
        int b2, b1, b0;
        for (int w = 0; w < 8; w++)
            if (m_val[s][w] == 1'b0) return w;
        b2 = int'(m_lru[s][0]);
        b1 = int'(m_lru[s][1 + b2]);
        b0 = int'(m_lru[s][3 + 2 * b2 + b1]);
        return 4 * b2 + 2 * b1 + b0;
    endfunction

    task automatic do_hit(input int s, input int w, input bit d);
        checks++;
        if (bus.hit_ready !== 1'b1) begin
            errors++;
            $display("FAIL hit_ready_idle got %0b exp 1", bus.hit_ready);
        end
        bus.hit_valid = 1'b1;
        bus.hit_index = 3'(s);
        bus.hit_way   = 3'(w);
        bus.hit_dirty = d;
        @(posedge clk); #1;
        bus.hit_valid = 1'b0;
        bus.hit_dirty = 1'b0;
        m_touch(s, w);
        if (d && m_val[s][w]) m_dty[s][w] = 1'b1;
    endtask

    // One full allocation; hit_mode 0 none, 1 hit the victim once during FILL, 2 random hits.
    task automatic do_miss(input int idx, input bit fd, input int wb_wait, input int fill_wait,
                           input int hit_mode, input bit both_ack, output int way);
        int exp_v;
        bit exp_wb;
        int hs, hw;
        bit hd;
        checks++;
        if (bus.miss_ready !== 1'b1) begin
            errors++;
            $display("FAIL miss_ready_before got %0b exp 1", bus.miss_ready);
        end
        bus.miss_req   = 1'b1;
        bus.miss_index = 3'(idx);
        @(posedge clk); #1;
        bus.miss_req = 1'b0;
        exp_v  = m_victim(idx);
        exp_wb = m_val[idx][exp_v] & m_dty[idx][exp_v];
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (bus.wb_req !== exp_wb || bus.fill_req !== !exp_wb) begin
            errors++;
            $display("FAIL req_start got wb=%0b fill=%0b exp wb=%0b fill=%0b",
                     bus.wb_req, bus.fill_req, exp_wb, !exp_wb);
        end
        if (exp_wb) begin
            checks++;
            if (bus.wb_index !== 3'(idx) || bus.wb_way !== 3'(exp_v)) begin
                errors++;
                $display("FAIL wb_target got set=%0d way=%0d exp set=%0d way=%0d",
                         bus.wb_index, bus.wb_way, idx, exp_v);
            end
            for (int i = 0; i < wb_wait; i++) begin
                @(posedge clk); #1;
                checks++;
                if (bus.wb_req !== 1'b1 || bus.fill_req !== 1'b0) begin
                    errors++;
                    $display("FAIL wb_hold got wb=%0b fill=%0b exp wb=1 fill=0",
                             bus.wb_req, bus.fill_req);
                end
            end
            bus.wb_ack   = 1'b1;
            bus.fill_ack = both_ack;
            @(posedge clk); #1;
            bus.wb_ack   = 1'b0;
            bus.fill_ack = 1'b0;
            checks++;
            if (bus.fill_req !== 1'b1 || bus.wb_req !== 1'b0 || bus.miss_done !== 1'b0) begin
                errors++;
                $display("FAIL wb_to_fill got fill=%0b wb=%0b done=%0b exp fill=1 wb=0 done=0",
                         bus.fill_req, bus.wb_req, bus.miss_done);
            end
        end
        checks++;
        if (bus.fill_index !== 3'(idx) || bus.fill_way !== 3'(exp_v)) begin
            errors++;
            $display("FAIL fill_target got set=%0d way=%0d exp set=%0d way=%0d",
                     bus.fill_index, bus.fill_way, idx, exp_v);
        end
        for (int i = 0; i < fill_wait; i++) begin
            if (hit_mode == 1 && i == 0) begin
                hs = idx; hw = exp_v; hd = 1'b0;
            end else begin
                hs = $urandom_range(0, 7); hw = $urandom_range(0, 7); hd = 1'($urandom_range(0, 1));
            end
            if (hit_mode == 2 || (hit_mode == 1 && i == 0)) begin
                bus.hit_valid = 1'b1;
                bus.hit_index = 3'(hs);
                bus.hit_way   = 3'(hw);
                bus.hit_dirty = hd;
                m_touch(hs, hw);
                if (hd && m_val[hs][hw]) m_dty[hs][hw] = 1'b1;
            end
            @(posedge clk); #1;
            bus.hit_valid = 1'b0;
            bus.hit_dirty = 1'b0;
            checks++;
            if (bus.fill_req !== 1'b1 || bus.fill_way !== 3'(exp_v)) begin
                errors++;
                $display("FAIL fill_hold got req=%0b way=%0d exp req=1 way=%0d",
                         bus.fill_req, bus.fill_way, exp_v);
            end
        end
        bus.fill_ack   = 1'b1;
        bus.fill_dirty = fd;
        @(posedge clk); #1;
        bus.fill_ack   = 1'b0;
        bus.fill_dirty = 1'b0;
        checks++;
        if (bus.miss_done !== 1'b1 || bus.miss_way !== 3'(exp_v) || bus.fill_req !== 1'b0 ||
            bus.hit_ready !== 1'b0 || bus.miss_ready !== 1'b0) begin
            errors++;
            $display("FAIL done got done=%0b way=%0d fill=%0b hrdy=%0b mrdy=%0b exp 1 %0d 0 0 0",
                     bus.miss_done, bus.miss_way, bus.fill_req, bus.hit_ready, bus.miss_ready, exp_v);
        end
        m_val[idx][exp_v] = 1'b1;
        m_dty[idx][exp_v] = fd;
        m_touch(idx, exp_v);
        @(posedge clk); #1;
        checks++;
        if (bus.miss_done !== 1'b0 || bus.miss_ready !== 1'b1 || bus.hit_ready !== 1'b1) begin
            errors++;
            $display("FAIL after_done got done=%0b mrdy=%0b hrdy=%0b exp 0 1 1",
                     bus.miss_done, bus.miss_ready, bus.hit_ready);
        end
        way = exp_v;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        checks++;
        if (bus.wb_req !== 1'b0 || bus.fill_req !== 1'b0 || bus.miss_done !== 1'b0 ||
            bus.miss_way !== 3'd0 || bus.miss_ready !== 1'b1 || bus.hit_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_outputs got wb=%0b fill=%0b done=%0b way=%0d mrdy=%0b hrdy=%0b",
                     bus.wb_req, bus.fill_req, bus.miss_done, bus.miss_way, bus.miss_ready, bus.hit_ready);
        end
        m_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_fill_order();
        int w;
        for (int i = 0; i < 8; i++) begin
            do_miss(0, 1'b0, 0, 0, 0, 1'b0, w);
            checks++;
            if (w != i) begin
                errors++;
                $display("FAIL fill_order got %0d exp %0d", w, i);
            end
        end
    endtask

    task automatic test_plru();
        int w;
        do_miss(0, 1'b0, 0, 0, 0, 1'b0, w);
        checks++;
        if (w != 0) begin errors++; $display("FAIL plru_ninth got %0d exp 0", w); end
        do_hit(0, 0, 1'b0);
        do_miss(0, 1'b0, 0, 0, 0, 1'b0, w);
        checks++;
        if (w != 4) begin errors++; $display("FAIL plru_after_hit got %0d exp 4", w); end
    endtask

    task automatic test_writeback();
        int w;
        for (int i = 0; i < 8; i++) do_miss(1, (i == 0), 0, 0, 0, 1'b0, w);
        do_miss(1, 1'b0, 3, 0, 0, 1'b1, w);
        checks++;
        if (w != 0) begin errors++; $display("FAIL wb_victim got %0d exp 0", w); end
    endtask

    task automatic test_hit_during_fill();
        int w;
        for (int i = 0; i < 8; i++) do_miss(2, 1'b0, 0, 0, 0, 1'b0, w);
        do_miss(2, 1'b0, 0, 4, 1, 1'b0, w);
        checks++;
        if (w != 0) begin errors++; $display("FAIL frozen_victim got %0d exp 0", w); end
    endtask

    task automatic test_set_independence();
        int w;
        for (int i = 0; i < 8; i++) do_miss(4, 1'b0, 0, 0, 0, 1'b0, w);
        do_hit(3, 0, 1'b0);
        do_hit(3, 5, 1'b1);
        do_miss(4, 1'b0, 0, 0, 0, 1'b0, w);
        checks++;
        if (w != 0) begin errors++; $display("FAIL set_indep got %0d exp 0", w); end
    endtask

    task automatic test_stray_acks();
        bus.wb_ack     = 1'b1;
        bus.fill_ack   = 1'b1;
        bus.fill_dirty = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            checks++;
            if (bus.wb_req !== 1'b0 || bus.fill_req !== 1'b0 || bus.miss_done !== 1'b0 ||
                bus.miss_ready !== 1'b1) begin
                errors++;
                $display("FAIL stray_ack got wb=%0b fill=%0b done=%0b mrdy=%0b exp 0 0 0 1",
                         bus.wb_req, bus.fill_req, bus.miss_done, bus.miss_ready);
            end
        end
        bus.wb_ack     = 1'b0;
        bus.fill_ack   = 1'b0;
        bus.fill_dirty = 1'b0;
    endtask

    task automatic test_reset_mid_fill();
        int w;
        for (int i = 0; i < 3; i++) do_miss(5, 1'b1, 0, 0, 0, 1'b0, w);
        bus.miss_req   = 1'b1;
        bus.miss_index = 3'd5;
        @(posedge clk); #1;
        bus.miss_req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus.fill_req !== 1'b1 || bus.fill_way !== 3'd3) begin
            errors++;
            $display("FAIL pre_abort got req=%0b way=%0d exp 1 3", bus.fill_req, bus.fill_way);
        end
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.fill_req !== 1'b0 || bus.miss_ready !== 1'b1 || bus.hit_ready !== 1'b1) begin
            errors++;
            $display("FAIL async_reset got fill=%0b mrdy=%0b hrdy=%0b exp 0 1 1",
                     bus.fill_req, bus.miss_ready, bus.hit_ready);
        end
        m_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        do_miss(5, 1'b0, 0, 0, 0, 1'b0, w);
        checks++;
        if (w != 0) begin errors++; $display("FAIL post_reset_way got %0d exp 0", w); end
    endtask

    task automatic test_random();
        int w;
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 2) == 0)
                do_hit($urandom_range(0, 7), $urandom_range(0, 7), 1'($urandom_range(0, 1)));
            else
                do_miss($urandom_range(0, 3), 1'($urandom_range(0, 1)), $urandom_range(0, 2),
                        $urandom_range(0, 3), ($urandom_range(0, 1) == 1) ? 2 : 0,
                        1'($urandom_range(0, 1)), w);
        end
    endtask

    initial begin
        clk            = 1'b0;
        rst_n          = 1'b0;
        checks         = 0;
        errors         = 0;
        bus.hit_valid  = 1'b0;
        bus.hit_index  = '0;
        bus.hit_way    = '0;
        bus.hit_dirty  = 1'b0;
        bus.miss_req   = 1'b0;
        bus.miss_index = '0;
        bus.wb_ack     = 1'b0;
        bus.fill_ack   = 1'b0;
        bus.fill_dirty = 1'b0;
        test_reset();
        test_fill_order();
        test_plru();
        test_writeback();
        test_hit_during_fill();
        test_set_independence();
        test_stray_acks();
        test_reset_mid_fill();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
